// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single write port of a FIFO among NUM_REQ producers.
// Optional feature macro FIFO_ARB_BURST_EN: a winner keeps priority for up to BURST_LEN beats.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          reset_L,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          FIFO_full,
    output logic                          FIFO_wr,
    output logic [DATA_WIDTH-1:0]         FIFO_data_in,
    output logic [2:0]                    grant_id,
    output logic [1:0]                    arb_state,
    output logic [15:0]                   stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam int PW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1 || BURST_LEN > 16) begin : g_cfg_check
        $error("fifo_wr_arbiter: NUM_REQ must be 2..8 and BURST_LEN 1..16");
    end

    state_t                r_state, w_state_nxt;
    logic [PW-1:0]         r_ptr, w_ptr_nxt, w_win, w_idx_p;
    logic                  w_any, w_accept;
    int                    w_idx;
    logic                  r_wr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [2:0]            r_gid;
    logic [15:0]           r_stall_cnt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
    endfunction

    // Scan from the highest offset down so the lowest offset from r_ptr is the last (winning) write.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_any   = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        w_idx_p = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            w_idx_p = PW'(w_idx);
            if (req_valid[w_idx_p]) begin
                w_any = 1'b1;
                w_win = w_idx_p;
            end
        end
    end

    assign w_accept = reset_L && !FIFO_full && w_any;

    always_comb begin
        req_ready = '0;
        if (w_accept) req_ready[w_win] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_L) begin
            r_wr   <= 1'b0;
            r_data <= '0;
            r_gid  <= '0;
        end else begin
            r_wr <= w_accept;
            if (w_accept) begin
                r_data <= req_data[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
                r_gid  <= 3'(w_win);
            end
        end
    end

`ifdef FIFO_ARB_BURST_EN
    localparam int BW = $clog2(BURST_LEN + 1);
    logic [BW-1:0] r_burst_cnt, w_burst_nxt;

    // r_burst_cnt counts beats already taken by the producer at r_ptr in its current burst.
    always_comb begin
        w_ptr_nxt   = r_ptr;
        w_burst_nxt = r_burst_cnt;
        if (w_accept) begin
            w_burst_nxt = (w_win == r_ptr) ? r_burst_cnt + 1'b1 : BW'(1);
            if (w_burst_nxt == BW'(BURST_LEN)) begin
                w_ptr_nxt   = ptr_inc(w_win);
                w_burst_nxt = '0;
            end else begin
                w_ptr_nxt = w_win;
            end
        end else if (r_burst_cnt != '0 && !req_valid[r_ptr]) begin
            w_ptr_nxt   = ptr_inc(r_ptr);
            w_burst_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) r_burst_cnt <= '0;
        else          r_burst_cnt <= w_burst_nxt;
    end
`else
    assign w_ptr_nxt = w_accept ? ptr_inc(w_win) : r_ptr;
`endif

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) r_ptr <= '0;
        else          r_ptr <= w_ptr_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) w_state_nxt = FIFO_full ? ST_STALL : ST_RUN;
            end
            ST_RUN: begin
                if (!w_any)        w_state_nxt = ST_IDLE;
                else if (FIFO_full) w_state_nxt = ST_STALL;
            end
            ST_STALL: begin
                if (!FIFO_full)  w_state_nxt = w_any ? ST_RUN : ST_IDLE;
                else if (!w_any) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= ST_IDLE;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_STALL && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign FIFO_wr      = r_wr;
    assign FIFO_data_in = r_data;
    assign grant_id     = r_gid;
    assign arb_state    = r_state;
    assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, corner sequences, randomized run vs model.
// Follows FIFO_ARB_BURST_EN so the expectations match the build being tested.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int BL = 4;

    logic              clk = 1'b0;
    logic              reset_L = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              FIFO_full = 1'b0;
    logic              FIFO_wr;
    logic [DW-1:0]     FIFO_data_in;
    logic [2:0]        grant_id;
    logic [1:0]        arb_state;
    logic [15:0]       stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .FIFO_full    (FIFO_full),
        .FIFO_wr      (FIFO_wr),
        .FIFO_data_in (FIFO_data_in),
        .grant_id     (grant_id),
        .arb_state    (arb_state),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: arbitration and FSM rules evaluated directly with integers.
    int          m_ptr, m_burst, m_win, m_gid, m_state, m_stall;
    bit          m_wr;
    logic [7:0]  m_data;
    logic [3:0]  m_ready;

    function void model_reset();
        m_ptr = 0; m_burst = 0; m_win = -1; m_gid = 0;
        m_state = 0; m_stall = 0; m_wr = 0; m_data = '0; m_ready = '0;
    endfunction

    function void model_arb(input logic [3:0] v, input logic f);
        m_win = -1;
        if (!f) begin
            for (int k = 0; k < NR; k++) begin
                if (m_win < 0 && v[(m_ptr + k) % NR]) m_win = (m_ptr + k) % NR;
            end
        end
        m_ready = (m_win >= 0) ? 4'(1 << m_win) : 4'b0000;
    endfunction

    function void model_update(input logic [3:0] v, input logic f, input logic [31:0] d);
        if (m_state == 2 && m_stall < 65535) m_stall++;
        m_state = (v == 4'b0000) ? 0 : (f ? 2 : 1);
        m_wr = (m_win >= 0);
        if (m_wr) begin
            m_data = d[m_win*8 +: 8];
            m_gid  = m_win;
        end
`ifdef FIFO_ARB_BURST_EN
        if (m_wr) begin
            m_burst = (m_win == m_ptr) ? m_burst + 1 : 1;
            if (m_burst == BL) begin
                m_ptr = (m_win + 1) % NR;
                m_burst = 0;
            end else begin
                m_ptr = m_win;
            end
        end else if (m_burst != 0 && !v[m_ptr]) begin
            m_ptr = (m_ptr + 1) % NR;
            m_burst = 0;
        end
`else
        if (m_wr) m_ptr = (m_win + 1) % NR;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check req_ready before the edge, registered outputs after it.
    task automatic step(input logic [3:0] v, input logic f, input logic [31:0] d,
                        output logic [3:0] rdy);
        @(negedge clk);
        req_valid = v;
        FIFO_full = f;
        req_data  = d;
        #1;
        model_arb(v, f);
        rdy = req_ready;
        check("ready", 32'(req_ready), 32'(m_ready));
        @(posedge clk);
        #1;
        model_update(v, f, d);
        check("wr",    32'(FIFO_wr),      32'(m_wr));
        check("data",  32'(FIFO_data_in), 32'(m_data));
        check("gid",   32'(grant_id),     32'(m_gid));
        check("state", 32'(arb_state),    32'(m_state));
        check("stall", 32'(stall_cnt),    32'(m_stall));
    endtask

    typedef struct {
        logic [3:0]  v;
        logic        f;
        logic [3:0]  rdy;
        logic        wr;
        logic [2:0]  gid;
        logic [1:0]  st;
        logic [15:0] sc;
    } vec_t;

    vec_t tbl[$];

    function void add_vec(input logic [3:0] v, input logic f, input logic [3:0] rdy,
                          input logic wr, input logic [2:0] gid, input logic [1:0] st,
                          input logic [15:0] sc);
        tbl.push_back('{v, f, rdy, wr, gid, st, sc});
    endfunction

    task automatic reset_phase();
        reset_L = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 4'($urandom);
            FIFO_full = 1'($urandom);
            req_data  = $urandom;
            #1;
            check("rst_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
            check("rst_wr",    32'(FIFO_wr),   32'd0);
            check("rst_state", 32'(arb_state), 32'd0);
            check("rst_stall", 32'(stall_cnt), 32'd0);
        end
        model_reset();
        @(negedge clk);
        req_valid = '0;
        FIFO_full = 1'b0;
        reset_L   = 1'b1;
    endtask

    initial begin
        logic [3:0]  rdy;
        logic [31:0] tdata;
        logic [7:0]  exp_d;

        model_reset();
        tdata = 32'hD3C2B1A0;

`ifdef FIFO_ARB_BURST_EN
        for (int i = 0; i < 4; i++) add_vec(4'b0011, 1'b0, 4'b0001, 1'b1, 3'd0, 2'd1, 16'd0);
        for (int i = 0; i < 4; i++) add_vec(4'b0011, 1'b0, 4'b0010, 1'b1, 3'd1, 2'd1, 16'd0);
        add_vec(4'b0011, 1'b0, 4'b0001, 1'b1, 3'd0, 2'd1, 16'd0);
        add_vec(4'b0011, 1'b0, 4'b0001, 1'b1, 3'd0, 2'd1, 16'd0);
        add_vec(4'b0011, 1'b1, 4'b0000, 1'b0, 3'd0, 2'd2, 16'd0);
        add_vec(4'b0011, 1'b1, 4'b0000, 1'b0, 3'd0, 2'd2, 16'd1);
        add_vec(4'b0011, 1'b0, 4'b0001, 1'b1, 3'd0, 2'd1, 16'd2);
        add_vec(4'b0011, 1'b0, 4'b0001, 1'b1, 3'd0, 2'd1, 16'd2);
        add_vec(4'b0011, 1'b0, 4'b0010, 1'b1, 3'd1, 2'd1, 16'd2);
        add_vec(4'b0000, 1'b0, 4'b0000, 1'b0, 3'd1, 2'd0, 16'd2);
`else
        for (int i = 0; i < 8; i++)
            add_vec(4'b1111, 1'b0, 4'(1 << (i % 4)), 1'b1, 3'(i % 4), 2'd1, 16'd0);
        for (int i = 0; i < 2; i++) begin
            add_vec(4'b1010, 1'b0, 4'b0010, 1'b1, 3'd1, 2'd1, 16'd0);
            add_vec(4'b1010, 1'b0, 4'b1000, 1'b1, 3'd3, 2'd1, 16'd0);
        end
        add_vec(4'b0100, 1'b0, 4'b0100, 1'b1, 3'd2, 2'd1, 16'd0);
        add_vec(4'b0000, 1'b0, 4'b0000, 1'b0, 3'd2, 2'd0, 16'd0);
        for (int i = 0; i < 5; i++)
            add_vec(4'b0001, 1'b1, 4'b0000, 1'b0, 3'd2, 2'd2, 16'(i));
        add_vec(4'b0001, 1'b0, 4'b0001, 1'b1, 3'd0, 2'd1, 16'd5);
        add_vec(4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 2'd0, 16'd5);
`endif

        reset_phase();

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].f, tdata, rdy);
            exp_d = tdata[int'(tbl[i].gid)*8 +: 8];
            check($sformatf("tbl%0d_ready", i), 32'(rdy),          32'(tbl[i].rdy));
            check($sformatf("tbl%0d_wr", i),    32'(FIFO_wr),      32'(tbl[i].wr));
            check($sformatf("tbl%0d_gid", i),   32'(grant_id),     32'(tbl[i].gid));
            check($sformatf("tbl%0d_data", i),  32'(FIFO_data_in), 32'(exp_d));
            check($sformatf("tbl%0d_state", i), 32'(arb_state),    32'(tbl[i].st));
            check($sformatf("tbl%0d_stall", i), 32'(stall_cnt),    32'(tbl[i].sc));
        end

        // Reset landing in the cycle after an accept discards the pending write at once.
        step(4'b0100, 1'b0, tdata, rdy);
        check("pre_rst_wr", 32'(FIFO_wr), 32'd1);
        #2;
        reset_L = 1'b0;
        #1;
        check("async_rst_wr",    32'(FIFO_wr),   32'd0);
        check("async_rst_ready", 32'(req_ready), 32'd0);
        check("async_rst_state", 32'(arb_state), 32'd0);
        model_reset();
        @(negedge clk);
        req_valid = '0;
        FIFO_full = 1'b0;
        @(negedge clk);
        reset_L = 1'b1;
        step(4'b0110, 1'b0, tdata, rdy);
        check("first_accept_lowest", 32'(rdy), 32'b0010);
        check("first_accept_gid",    32'(grant_id), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] v;
            logic       f;
            v = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
            f = ($urandom_range(0, 3) == 0);
            step(v, f, $urandom, rdy);
            check("rand_onehot", 32'($countones(rdy) <= 1), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
